// File: rtl/vfd_disp_tx_if.sv
// rtl/vfd_disp_tx_if.sv - tick/value inputs and serial driver lines of vfd_disp_tx
interface vfd_disp_tx_if;
  logic       pluse_us;
  logic [7:0] freq;
  logic       vfd_sclk;
  logic       vfd_sdat;
  logic       vfd_load;
  logic       vfd_blank;
  logic       busy;

  modport master (
    input  pluse_us,
    input  freq,
    output vfd_sclk,
    output vfd_sdat,
    output vfd_load,
    output vfd_blank,
    output busy
  );

  modport slave (
    output pluse_us,
    output freq,
    input  vfd_sclk,
    input  vfd_sdat,
    input  vfd_load,
    input  vfd_blank,
    input  busy
  );
endinterface

// File: rtl/vfd_disp_tx.sv
// rtl/vfd_disp_tx.sv - three-digit multiplexed VFD serial transmitter
// Optional `define VFD_LZB_EN enables leading-zero blanking of hundreds/tens.
module vfd_disp_tx #(
  parameter int SCLK_HALF = 4,
  parameter int SLOT_US   = 1000
) (
  input  logic          clk_sys,
  input  logic          rst,
  vfd_disp_tx_if.master bus
);

  localparam int SW = (SLOT_US > 1) ? $clog2(SLOT_US) : 1;
  localparam int HW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_US - 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(SCLK_HALF - 1);

  typedef enum logic [2:0] {
    S_WAIT,
    S_CONV,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_LOAD
  } state_t;

  state_t        state;
  state_t        state_n;

  logic [SW-1:0] slot_cnt;
  logic          slot_req;
  logic          take_req;

  logic [1:0]    digit;
  logic [3:0]    bcd_h;
  logic [3:0]    bcd_t;
  logic [3:0]    bcd_o;
  logic [19:0]   dd;
  logic [19:0]   dd_adj;
  logic [19:0]   dd_n;
  logic [2:0]    conv_cnt;

  logic [HW-1:0] half_cnt;
  logic          half_done;
  logic [3:0]    bit_idx;
  logic [3:0]    bit_idx_n;

  logic [3:0]    src_h;
  logic [3:0]    src_t;
  logic [3:0]    src_o;
  logic [7:0]    seg;
  logic [15:0]   frame;

  logic          blank_clr;
  logic          sclk_r;
  logic          sdat_r;
  logic          load_r;
  logic          blank_r;
  logic          busy_r;

  function automatic logic [7:0] seg_of(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hFC;
      4'd1:    s = 8'h60;
      4'd2:    s = 8'hDA;
      4'd3:    s = 8'hF2;
      4'd4:    s = 8'h66;
      4'd5:    s = 8'hB6;
      4'd6:    s = 8'hBE;
      4'd7:    s = 8'hE0;
      4'd8:    s = 8'hFE;
      4'd9:    s = 8'hF6;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  // Requests are a single sticky bit: a wrap while one is pending is lost.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      slot_cnt <= '0;
      slot_req <= 1'b0;
    end else begin
      if (bus.pluse_us) begin
        slot_cnt <= (slot_cnt == SLOT_LAST) ? '0 : slot_cnt + SW'(1);
      end
      if (bus.pluse_us && (slot_cnt == SLOT_LAST)) begin
        slot_req <= 1'b1;
      end else if (take_req) begin
        slot_req <= 1'b0;
      end
    end
  end

  // One double-dabble step: add 3 to every nibble >= 5, then shift left.
  always_comb begin
    dd_adj = dd;
    if (dd_adj[11:8]  >= 4'd5) dd_adj[11:8]  = dd_adj[11:8]  + 4'd3;
    if (dd_adj[15:12] >= 4'd5) dd_adj[15:12] = dd_adj[15:12] + 4'd3;
    if (dd_adj[19:16] >= 4'd5) dd_adj[19:16] = dd_adj[19:16] + 4'd3;
    dd_n = {dd_adj[18:0], 1'b0};
  end

  // While leaving CONV the held digits are not yet written, so use the final step.
  always_comb begin
    src_h = bcd_h;
    src_t = bcd_t;
    src_o = bcd_o;
    if (state == S_CONV) begin
      src_h = dd_n[19:16];
      src_t = dd_n[15:12];
      src_o = dd_n[11:8];
    end
    case (digit)
      2'd0:    seg = seg_of(src_h);
      2'd1:    seg = seg_of(src_t);
      default: seg = seg_of(src_o);
    endcase
`ifdef VFD_LZB_EN
    if ((digit == 2'd0) && (src_h == 4'd0)) seg = 8'h00;
    if ((digit == 2'd1) && (src_h == 4'd0) && (src_t == 4'd0)) seg = 8'h00;
`endif
    frame = {5'b00000, digit == 2'd2, digit == 2'd1, digit == 2'd0, seg};
  end

  assign half_done = (half_cnt == HALF_LAST);

  always_comb begin
    state_n   = state;
    bit_idx_n = bit_idx;
    take_req  = 1'b0;
    case (state)
      S_WAIT: begin
        if (slot_req) begin
          take_req  = 1'b1;
          bit_idx_n = 4'd15;
          state_n   = (digit == 2'd0) ? S_CONV : S_SHIFT_LO;
        end
      end
      S_CONV: begin
        if (conv_cnt == 3'd7) state_n = S_SHIFT_LO;
      end
      S_SHIFT_LO: begin
        if (half_done) state_n = S_SHIFT_HI;
      end
      S_SHIFT_HI: begin
        if (half_done) begin
          if (bit_idx == 4'd0) begin
            state_n = S_LOAD;
          end else begin
            state_n   = S_SHIFT_LO;
            bit_idx_n = bit_idx - 4'd1;
          end
        end
      end
      S_LOAD: begin
        if (half_done) state_n = S_WAIT;
      end
      default: state_n = S_WAIT;
    endcase
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state     <= S_WAIT;
      bit_idx   <= 4'd0;
      half_cnt  <= '0;
      digit     <= 2'd0;
      dd        <= 20'd0;
      conv_cnt  <= 3'd0;
      bcd_h     <= 4'd0;
      bcd_t     <= 4'd0;
      bcd_o     <= 4'd0;
      sclk_r    <= 1'b0;
      sdat_r    <= 1'b0;
      load_r    <= 1'b0;
      blank_r   <= 1'b1;
      busy_r    <= 1'b0;
      blank_clr <= 1'b0;
    end else begin
      state    <= state_n;
      bit_idx  <= bit_idx_n;
      half_cnt <= (state_n != state) ? '0 : half_cnt + HW'(1);

      if ((state == S_WAIT) && (state_n == S_CONV)) begin
        dd       <= {12'd0, bus.freq};
        conv_cnt <= 3'd0;
      end else if (state == S_CONV) begin
        dd       <= dd_n;
        conv_cnt <= conv_cnt + 3'd1;
        if (conv_cnt == 3'd7) begin
          bcd_h <= dd_n[19:16];
          bcd_t <= dd_n[15:12];
          bcd_o <= dd_n[11:8];
        end
      end

      if ((state == S_LOAD) && (state_n == S_WAIT)) begin
        digit <= (digit == 2'd2) ? 2'd0 : digit + 2'd1;
      end

      sclk_r <= (state_n == S_SHIFT_HI);
      load_r <= (state_n == S_LOAD);
      busy_r <= (state_n != S_WAIT);
      if ((state_n == S_SHIFT_LO) && (state != S_SHIFT_LO)) begin
        sdat_r <= frame[bit_idx_n];
      end

      // Unblank one cycle after the latch pulse; a new frame starting then keeps it blanked.
      blank_clr <= (state == S_LOAD) && (state_n == S_WAIT);
      if ((state == S_WAIT) && (state_n != S_WAIT)) begin
        blank_r <= 1'b1;
      end else if (blank_clr) begin
        blank_r <= 1'b0;
      end
    end
  end

  assign bus.vfd_sclk  = sclk_r;
  assign bus.vfd_sdat  = sdat_r;
  assign bus.vfd_load  = load_r;
  assign bus.vfd_blank = blank_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_vfd_disp_tx.sv
// tb/tb_vfd_disp_tx.sv - scoreboard bench for vfd_disp_tx (follows VFD_LZB_EN)
`timescale 1ns/1ps
module tb_vfd_disp_tx;

  localparam int SCLK_HALF = 4;
  localparam int SLOT_US   = 40;
  localparam logic [7:0] SEG_TAB [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                                          8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};

  logic clk_sys = 1'b0;
  logic rst     = 1'b1;

  vfd_disp_tx_if bus();

  vfd_disp_tx #(.SCLK_HALF(SCLK_HALF), .SLOT_US(SLOT_US)) dut (
    .clk_sys(clk_sys),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk_sys = ~clk_sys;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_q [$];

  function automatic void check(string nm, int act, int exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endfunction

  function automatic logic [15:0] model_frame(int v, int d);
    int dig [3];
    logic [7:0] s;
    logic [7:0] g;
    dig[0] = v / 100;
    dig[1] = (v / 10) % 10;
    dig[2] = v % 10;
    s = SEG_TAB[dig[d]];
`ifdef VFD_LZB_EN
    if ((d == 0 && v < 100) || (d == 1 && v < 10)) s = 8'h00;
`endif
    g = 8'(1 << d);
    return {g, s};
  endfunction

  bit fast = 1'b0;
  int pdiv = 0;
  initial begin
    bus.pluse_us = 1'b0;
    forever begin
      @(negedge clk_sys);
      pdiv = (pdiv == 4) ? 0 : pdiv + 1;
      bus.pluse_us = fast || (pdiv == 0);
    end
  end

  logic [15:0] shreg   = '0;
  int  nbits    = 0;
  int  n_loads  = 0;
  int  load_w   = 0;
  int  gap      = 0;
  bit  gap_ok   = 1'b0;
  bit  fast_prev = 1'b0;
  bit  blank_pend = 1'b0;
  bit  sclk_p = 1'b0;
  bit  load_p = 1'b0;
  bit  busy_p = 1'b0;

  always @(negedge clk_sys) begin
    if (rst) begin
      nbits      = 0;
      load_w     = 0;
      gap_ok     = 1'b0;
      blank_pend = 1'b0;
    end else begin
      if (blank_pend) begin
        check("blank_after_load", int'(bus.vfd_blank), int'(bus.busy));
        blank_pend = 1'b0;
      end
      if (bus.vfd_sclk && !sclk_p) begin
        shreg = {shreg[14:0], bus.vfd_sdat};
        nbits++;
      end
      if (bus.vfd_load && !load_p) begin
        check("frame_bits", nbits, 16);
        check("blank_in_frame", int'(bus.vfd_blank), 1);
        if (exp_q.size() == 0) check("frame_unexpected", int'(shreg), -1);
        else check("frame", int'(shreg), int'(exp_q.pop_front()));
        nbits = 0;
        n_loads++;
      end
      if (bus.vfd_load) load_w++;
      if (!bus.vfd_load && load_p) begin
        check("load_width", load_w, SCLK_HALF);
        load_w     = 0;
        blank_pend = 1'b1;
      end
      if (bus.busy && !busy_p) begin
        if (gap_ok && fast_prev && fast) check("start_gap", gap, 1);
        fast_prev = fast;
        gap_ok    = 1'b0;
      end else if (!bus.busy && busy_p) begin
        gap    = 1;
        gap_ok = 1'b1;
      end else if (!bus.busy) begin
        gap++;
      end
    end
    sclk_p = bus.vfd_sclk;
    load_p = bus.vfd_load;
    busy_p = bus.busy;
  end

  task automatic wait_loads(int target);
    int t = 0;
    while (n_loads < target && t < 3000) begin
      @(negedge clk_sys);
      t++;
    end
    check("load_wait", int'(n_loads >= target), 1);
  endtask

  task automatic wait_busy(logic lvl);
    int t = 0;
    while (bus.busy !== lvl && t < 3000) begin
      @(negedge clk_sys);
      t++;
    end
    check("busy_wait", int'(bus.busy === lvl), 1);
  endtask

  task automatic start_cycle(int v);
    bus.freq = 8'(v);
    for (int d = 0; d < 3; d++) exp_q.push_back(model_frame(v, d));
  endtask

  // One refresh cycle of value v; freq is disturbed mid digit-1 shift.
  task automatic run_cycle(int v, int glitch);
    int base = n_loads;
    start_cycle(v);
    wait_loads(base + 1);
    wait_busy(1'b0);
    wait_busy(1'b1);
    repeat (30) @(negedge clk_sys);
    bus.freq = 8'(glitch);
    wait_loads(base + 3);
  endtask

  task automatic check_reset_outputs();
    check("rst_sclk",  int'(bus.vfd_sclk),  0);
    check("rst_sdat",  int'(bus.vfd_sdat),  0);
    check("rst_load",  int'(bus.vfd_load),  0);
    check("rst_blank", int'(bus.vfd_blank), 1);
    check("rst_busy",  int'(bus.busy),      0);
  endtask

  initial begin
    int base;
    int t;
    int w;
    bus.freq = 8'd0;
    repeat (3) @(negedge clk_sys);
    check_reset_outputs();
    rst = 1'b0;

    run_cycle(123, $urandom_range(0, 255));
    run_cycle(5,   $urandom_range(0, 255));
    run_cycle(0,   $urandom_range(0, 255));
    run_cycle(255, 7);
    run_cycle(7,   $urandom_range(0, 255));
    for (int i = 0; i < 4; i++) run_cycle($urandom_range(0, 255), $urandom_range(0, 255));

    fast = 1'b1;
    for (int i = 0; i < 5; i++) run_cycle($urandom_range(0, 255), $urandom_range(0, 255));

    base = n_loads;
    start_cycle($urandom_range(0, 255));
    wait_loads(base + 1);
    wait_busy(1'b0);
    wait_busy(1'b1);
    t = 0;
    while (nbits < 8 && t < 3000) begin
      @(negedge clk_sys);
      t++;
    end
    check("reach_bit7", int'(nbits >= 8), 1);
    rst = 1'b1;
    #1;
    check_reset_outputs();
    exp_q.delete();
    bus.freq = 8'($urandom_range(0, 255));
    repeat (5) @(negedge clk_sys);
    w = $urandom_range(0, 99);
    bus.freq = 8'(w);
    rst = 1'b0;
    run_cycle(w, $urandom_range(0, 255));

    fast = 1'b0;
    run_cycle($urandom_range(0, 255), $urandom_range(0, 255));
    repeat (20) @(negedge clk_sys);
    check("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
